// File: rtl/osiris_lb_pkg.sv
// Shared definitions for the PS-facing linebuffer blocks:
// fetch FSM state encoding, bank indices and line geometry helper.
`default_nettype none

package osiris_lb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lb_state_t;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Pixels are 8 bits, so four pixels pack into each 32-bit word.
  function automatic int unsigned words_per_line(input int unsigned width);
    return width / 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lb_fetch_timer.sv
// Timeout counter for outstanding PS transfers; expired is high once the
// count has advanced TIMEOUT_CYCLES-1 times since the last clear.
`default_nettype none

module lb_fetch_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic pclk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a caller that keeps run high never sees a wrap.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/line_fetch_scheduler.sv
// Issues one PS line fetch per display line into a ping-pong linebuffer,
// tracks bank fill state, swaps the display bank and flags underruns/faults.
`default_nettype none

module line_fetch_scheduler
  import osiris_lb_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LINE_IDX_WIDTH = 12
) (
  input  logic                      pclk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ADDR_WIDTH-1:0]     fb_base,
  input  logic [15:0]               line_stride,
  input  logic                      line_req,
  input  logic                      frame_req,
  input  logic                      clr_status,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [ADDR_WIDTH-1:0]     fetch_addr,
  output logic [15:0]               fetch_len,
  output logic                      fetch_bank,
  input  logic                      fetch_done,
  input  logic                      fetch_err,
  output logic                      rd_bank,
  output logic [LINE_IDX_WIDTH-1:0] line_idx,
  output logic                      busy,
  output logic                      underrun,
  output logic                      fetch_fault
);

  localparam logic [15:0]               WORDS  = 16'(words_per_line(DISPLAY_WIDTH));
  localparam logic [LINE_IDX_WIDTH-1:0] HEIGHT = LINE_IDX_WIDTH'(DISPLAY_HEIGHT);

  lb_state_t                 state, state_nxt;
  logic [1:0]                bank_full, full_nxt, full_after_done;
  logic [ADDR_WIDTH-1:0]     line_addr, line_addr_nxt, addr_nxt;
  logic [15:0]               stride, stride_nxt;
  logic [LINE_IDX_WIDTH-1:0] idx_nxt;
  logic                      frame_pending, pending_nxt;
  logic                      valid_nxt, bank_nxt, rd_nxt;
  logic                      underrun_nxt, fault_nxt, underrun_set, fault_set;
  logic                      restart, wait_exit;
  logic                      timer_clear, timer_run, timer_expired;
  logic                      wr_bank;

  assign wr_bank   = ~rd_bank;
  assign fetch_len = WORDS;
  assign busy      = (state != ST_IDLE);

  lb_fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .pclk    (pclk),
    .reset   (reset),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    valid_nxt       = fetch_valid;
    addr_nxt        = fetch_addr;
    bank_nxt        = fetch_bank;
    rd_nxt          = rd_bank;
    full_after_done = bank_full;
    full_nxt        = bank_full;
    idx_nxt         = line_idx;
    line_addr_nxt   = line_addr;
    stride_nxt      = stride;
    pending_nxt     = frame_pending | frame_req;
    underrun_set    = 1'b0;
    fault_set       = 1'b0;
    timer_clear     = 1'b0;
    timer_run       = 1'b0;
    restart         = 1'b0;
    wait_exit       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (frame_pending) begin
          restart = 1'b1;
        end else if (enable && (line_idx < HEIGHT) && !bank_full[wr_bank]) begin
          state_nxt = ST_REQ;
          valid_nxt = 1'b1;
          addr_nxt  = line_addr;
          bank_nxt  = wr_bank;
        end
      end
      ST_REQ: begin
        if (fetch_ready) begin
          state_nxt   = ST_WAIT;
          valid_nxt   = 1'b0;
          timer_clear = 1'b1;
        end
      end
      ST_WAIT: begin
        timer_run = 1'b1;
        // An error wins over a coincident done; a done on the last timer
        // cycle still counts as a completed transfer.
        if (fetch_err || (timer_expired && !fetch_done)) begin
          fault_set = 1'b1;
          wait_exit = 1'b1;
        end else if (fetch_done) begin
          wait_exit = 1'b1;
          if (!frame_pending) full_after_done[fetch_bank] = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (wait_exit) begin
      state_nxt = ST_IDLE;
      if (!frame_pending) begin
        idx_nxt       = line_idx + 1'b1;
        line_addr_nxt = line_addr + {{(ADDR_WIDTH-16){1'b0}}, stride};
      end
    end

    // Swap decisions see a same-cycle completion, so done+line_req never underruns.
    full_nxt = full_after_done;
    if (line_req) begin
      if (full_after_done[wr_bank]) begin
        rd_nxt            = ~rd_bank;
        full_nxt[rd_bank] = 1'b0;
      end else begin
        underrun_set = 1'b1;
      end
    end

    if (restart) begin
      line_addr_nxt = fb_base;
      stride_nxt    = line_stride;
      idx_nxt       = '0;
      full_nxt      = 2'b00;
      rd_nxt        = BANK0;
      pending_nxt   = frame_req;
    end

    underrun_nxt = underrun_set | (underrun & ~clr_status);
    fault_nxt    = fault_set | (fetch_fault & ~clr_status);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      fetch_valid   <= 1'b0;
      fetch_addr    <= '0;
      fetch_bank    <= BANK0;
      rd_bank       <= BANK0;
      bank_full     <= 2'b00;
      line_idx      <= '0;
      line_addr     <= '0;
      stride        <= '0;
      underrun      <= 1'b0;
      fetch_fault   <= 1'b0;
      frame_pending <= 1'b0;
    end else begin
      fetch_valid   <= valid_nxt;
      fetch_addr    <= addr_nxt;
      fetch_bank    <= bank_nxt;
      rd_bank       <= rd_nxt;
      bank_full     <= full_nxt;
      line_idx      <= idx_nxt;
      line_addr     <= line_addr_nxt;
      stride        <= stride_nxt;
      underrun      <= underrun_nxt;
      fetch_fault   <= fault_nxt;
      frame_pending <= pending_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_fetch_scheduler.sv
// Bench for line_fetch_scheduler: directed scenarios plus randomized line
// traffic, checked against a transaction-level linebuffer model.
`default_nettype none

module tb_line_fetch_scheduler;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] fb_base = '0;
  logic [15:0] line_stride = '0;
  logic        line_req = 1'b0, frame_req = 1'b0, clr_status = 1'b0;
  logic        fetch_ready = 1'b0, fetch_done = 1'b0, fetch_err = 1'b0;
  logic        fetch_valid, fetch_bank, rd_bank, busy, underrun, fetch_fault;
  logic [31:0] fetch_addr;
  logic [15:0] fetch_len;
  logic [11:0] line_idx;

  int checks = 0;
  int errors = 0;

  // Model: banks holding a complete line, display bank, frame geometry.
  logic        m_rd = 1'b0;
  logic [1:0]  m_full = 2'b00;
  int          m_idx = 0;
  logic [31:0] m_base = '0;
  logic [15:0] m_stride = '0;
  logic        m_underrun = 1'b0, m_fault = 1'b0, m_pending = 1'b0;

  line_fetch_scheduler #(
    .DISPLAY_WIDTH(640), .DISPLAY_HEIGHT(320), .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4096), .LINE_IDX_WIDTH(12)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .fb_base(fb_base),
    .line_stride(line_stride), .line_req(line_req), .frame_req(frame_req),
    .clr_status(clr_status), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_len(fetch_len), .fetch_bank(fetch_bank),
    .fetch_done(fetch_done), .fetch_err(fetch_err), .rd_bank(rd_bank),
    .line_idx(line_idx), .busy(busy), .underrun(underrun), .fetch_fault(fetch_fault)
  );

  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_line_req();
    if (m_full[~m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_rd = ~m_rd;
    end else begin
      m_underrun = 1'b1;
    end
  endtask

  task automatic pulse_lr();
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
    model_line_req();
    check("lr_rd_bank", rd_bank, m_rd);
    check("lr_underrun", underrun, m_underrun);
  endtask

  task automatic clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    m_underrun = 1'b0;
    m_fault = 1'b0;
    check("clr_underrun", underrun, 0);
    check("clr_fault", fetch_fault, 0);
  endtask

  task automatic model_restart();
    m_base = fb_base; m_stride = line_stride;
    m_idx = 0; m_full = 2'b00; m_rd = 1'b0; m_pending = 1'b0;
  endtask

  task automatic frame_start(input logic [31:0] base, input logic [15:0] str);
    enable = 1'b0;
    fb_base = base;
    line_stride = str;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    enable = 1'b1;
    model_restart();
    check("restart_idx", line_idx, 0);
    check("restart_rd", rd_bank, 0);
  endtask

  // kind: 0 done, 1 err, 2 timeout, 3 done+err. lr_mode: 0 none,
  // 1 line_req while waiting, 2 line_req together with completion.
  task automatic fetch_line(input int ready_lat, input int done_lat, input int kind,
                            input int lr_mode, input bit frame_mid);
    int n;
    logic [63:0] t;
    logic [31:0] exp_addr;
    logic exp_bank, bad;
    t = 64'(m_base) + 64'(m_idx) * 64'(m_stride);
    exp_addr = t[31:0];
    exp_bank = ~m_rd;
    n = 0;
    while (fetch_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check("fetch_issued", fetch_valid, 1);
    if (fetch_valid !== 1'b1) return;
    check("fetch_addr", fetch_addr, exp_addr);
    check("fetch_bank", fetch_bank, exp_bank);
    check("fetch_len", fetch_len, 160);
    check("busy_req", busy, 1);
    bad = 1'b0;
    for (int i = 0; i < ready_lat; i++) begin
      tick();
      if (fetch_valid !== 1'b1 || fetch_addr !== exp_addr || fetch_bank !== exp_bank) bad = 1'b1;
    end
    if (ready_lat > 0) check("req_hold", bad, 0);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check("valid_drop", fetch_valid, 0);
    if (frame_mid) begin
      frame_req = 1'b1;
      tick();
      frame_req = 1'b0;
      m_pending = 1'b1;
    end
    if (kind == 2) begin
      n = 0;
      while (busy === 1'b1 && n < 5000) begin tick(); n++; end
      check("timeout_cycles", 64'(n), 4096);
    end else begin
      for (int i = 0; i < done_lat; i++) tick();
      if (lr_mode == 1) pulse_lr();
      fetch_done = (kind == 0 || kind == 3);
      fetch_err  = (kind == 1 || kind == 3);
      line_req   = (lr_mode == 2);
      tick();
      fetch_done = 1'b0; fetch_err = 1'b0; line_req = 1'b0;
    end
    if (kind != 0) m_fault = 1'b1;
    else if (!m_pending) m_full[exp_bank] = 1'b1;
    if (!m_pending) m_idx++;
    if (lr_mode == 2) model_line_req();
    check("exit_rd_bank", rd_bank, m_rd);
    check("exit_underrun", underrun, m_underrun);
    check("exit_fault", fetch_fault, m_fault);
    if (m_pending) begin
      tick();
      model_restart();
    end
    check("line_idx", line_idx, 64'(m_idx));
  endtask

  initial begin
    int r, kind, lr;
    #2;
    check("rst_valid", fetch_valid, 0);
    check("rst_addr", fetch_addr, 0);
    check("rst_len", fetch_len, 160);
    check("rst_rd", rd_bank, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {underrun, fetch_fault}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Frame start and first bank swap.
    frame_start(32'h1000_0000, 16'd640);
    fetch_line(0, 2, 0, 0, 0);
    pulse_lr();
    fetch_line(0, 1, 0, 0, 0);

    // Underrun while waiting, then a late swap; flag sticky until cleared.
    pulse_lr();
    fetch_line(1, 3, 0, 1, 0);
    pulse_lr();
    check("underrun_sticky", underrun, 1);
    clr();

    // Completion and line_req in the same cycle.
    fetch_line(0, 1, 0, 2, 0);
    check("same_cycle_no_underrun", underrun, 0);

    // Timeout, error, done+error: fault set, bank stays empty.
    fetch_line(0, 0, 2, 0, 0);
    clr();
    fetch_line(0, 2, 1, 0, 0);
    clr();
    fetch_line(0, 1, 3, 0, 0);
    clr();

    // Backpressure.
    fetch_line(50, 2, 0, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (m_full[~m_rd]) pulse_lr();
      else if ($urandom_range(0, 5) == 0) pulse_lr();
      r = $urandom_range(0, 15);
      kind = (r < 12) ? 0 : (r < 15) ? 1 : 3;
      lr = $urandom_range(0, 2);
      fetch_line($urandom_range(0, 3), $urandom_range(0, 4), kind, lr, 0);
      if ($urandom_range(0, 7) == 0) clr();
    end

    // Finish the frame.
    while (m_idx < 320) begin
      if (m_full[~m_rd]) pulse_lr();
      fetch_line(0, 0, 0, (m_idx == 319) ? 0 : 2, 0);
    end
    pulse_lr();
    pulse_lr();
    r = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (fetch_valid !== 1'b0) r = 1; end
    check("frame_end_no_fetch", r, 0);
    check("frame_end_idx", line_idx, 320);
    clr();

    // frame_req during WAIT discards the result.
    frame_start(32'h2000_0000, 16'd1280);
    fetch_line(0, 0, 0, 0, 0);
    pulse_lr();
    fb_base = 32'h3000_0000;
    fetch_line(0, 2, 0, 0, 1);
    check("discard_rd", rd_bank, 0);
    fetch_line(0, 1, 0, 0, 0);

    // Address wrap.
    frame_start(32'hFFFF_FD80, 16'd640);
    fetch_line(0, 0, 0, 0, 0);
    pulse_lr();
    fetch_line(0, 0, 0, 0, 0);
    check("wrap_idx", line_idx, 2);

    // Async reset mid-REQ.
    pulse_lr();
    r = 0;
    while (fetch_valid !== 1'b1 && r < 20) begin tick(); r++; end
    check("pre_reset_req", fetch_valid, 1);
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("areset_valid", fetch_valid, 0);
    check("areset_addr_bank", {fetch_addr, fetch_bank, rd_bank}, 0);
    check("areset_idx_busy", {line_idx, busy, underrun, fetch_fault}, 0);
    fetch_done = 1'b1;
    #1 reset = 1'b0;
    tick();
    fetch_done = 1'b0;
    tick();
    check("post_reset_idle", {busy, fetch_valid, rd_bank}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
